// File: rtl/sysbus_io_bridge_if.sv
// sysbus_io_bridge_if: core request/response and IO slave handshake signals
interface sysbus_io_bridge_if;
  logic        cpu_req_valid;
  logic        cpu_req_write;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_data;
  logic        cpu_req_ready;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_data;
  logic        cpu_resp_err;
  logic        sysbus_o_io_valid;
  logic        sysbus_o_io_write;
  logic [31:0] sysbus_o_io_addr;
  logic [31:0] sysbus_o_io_data;
  logic        sysbus_i_io_ready;
  logic [31:0] sysbus_i_io_data;
  modport slave (
    input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_data,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_err,
    output sysbus_o_io_valid, sysbus_o_io_write, sysbus_o_io_addr, sysbus_o_io_data,
    input  sysbus_i_io_ready, sysbus_i_io_data
  );
  modport master (
    output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_data,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_err,
    input  sysbus_o_io_valid, sysbus_o_io_write, sysbus_o_io_addr, sysbus_o_io_data,
    output sysbus_i_io_ready, sysbus_i_io_data
  );
endinterface

// File: rtl/sysbus_io_bridge.sv
// sysbus_io_bridge: decodes single core requests into the IO window and runs the IO slave handshake
module sysbus_io_bridge #(
  parameter logic [31:0] IO_BASE   = 32'hfe000000,
  parameter logic [31:0] IO_MASK   = 32'hff000000,
  parameter int          TIMEOUT   = 1024,
  parameter int          TIMEOUT_W = 16
) (
  input logic clk,
  input logic rst,
  sysbus_io_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT - 1);
  state_t state, state_n;
  logic [TIMEOUT_W-1:0] cnt, cnt_n;
  logic io_valid_n, io_write_n, resp_valid_n, resp_err_n, hit;
  logic [31:0] io_addr_n, io_data_n, resp_data_n;
  assign bus.cpu_req_ready = state == IDLE && !bus.sysbus_i_io_ready && !rst;
  assign hit = (bus.cpu_req_addr & IO_MASK) == IO_BASE && bus.cpu_req_addr[1:0] == 2'b00;
  // next state, IO request registers and one-cycle response pulse
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    io_valid_n = bus.sysbus_o_io_valid;
    io_write_n = bus.sysbus_o_io_write;
    io_addr_n = bus.sysbus_o_io_addr;
    io_data_n = bus.sysbus_o_io_data;
    resp_valid_n = 1'b0;
    resp_err_n = 1'b0;
    resp_data_n = '0;
    case (state)
      IDLE: if (bus.cpu_req_valid && bus.cpu_req_ready) begin
        if (!hit) begin
          resp_valid_n = 1'b1;
          resp_err_n = 1'b1;
        end else begin
          state_n = REQ;
          cnt_n = '0;
          io_valid_n = 1'b1;
          io_write_n = bus.cpu_req_write;
          io_addr_n = bus.cpu_req_addr;
          io_data_n = bus.cpu_req_write ? bus.cpu_req_data : 32'h0;
        end
      end
      REQ: if (bus.sysbus_i_io_ready) begin
        state_n = DRAIN;
        io_valid_n = 1'b0;
        resp_valid_n = 1'b1;
        resp_data_n = bus.sysbus_o_io_write ? 32'h0 : bus.sysbus_i_io_data;
      end else if (cnt == LAST) begin
        state_n = DRAIN;
        io_valid_n = 1'b0;
        resp_valid_n = 1'b1;
        resp_err_n = 1'b1;
      end else begin
        cnt_n = cnt + TIMEOUT_W'(1);
      end
      DRAIN: state_n = bus.sysbus_i_io_ready ? DRAIN : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state and output registers; reset aborts any request in flight without a response
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.sysbus_o_io_valid <= 1'b0;
      bus.sysbus_o_io_write <= 1'b0;
      bus.sysbus_o_io_addr <= '0;
      bus.sysbus_o_io_data <= '0;
      bus.cpu_resp_valid <= 1'b0;
      bus.cpu_resp_err <= 1'b0;
      bus.cpu_resp_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bus.sysbus_o_io_valid <= io_valid_n;
      bus.sysbus_o_io_write <= io_write_n;
      bus.sysbus_o_io_addr <= io_addr_n;
      bus.sysbus_o_io_data <= io_data_n;
      bus.cpu_resp_valid <= resp_valid_n;
      bus.cpu_resp_err <= resp_err_n;
      bus.cpu_resp_data <= resp_data_n;
    end
  end
endmodule

// File: tb/tb_sysbus_io_bridge.sv
// tb_sysbus_io_bridge: randomized core/slave traffic checked every cycle against a transaction-level model
module tb_sysbus_io_bridge;
  localparam int TO = 8;
  localparam logic [31:0] BASE = 32'hfe000000;
  localparam logic [31:0] MASK = 32'hff000000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  sysbus_io_bridge_if bus();
  sysbus_io_bridge #(.IO_BASE(BASE), .IO_MASK(MASK), .TIMEOUT(TO), .TIMEOUT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic s_ready = 1'b0;
  logic [31:0] s_data = '0;
  int s_delay = 0;
  int s_wcnt = 0;
  logic s_never = 1'b0;
  logic s_stuck = 1'b0;
  logic s_fix_en = 1'b0;
  logic [31:0] s_fix = '0;
  assign bus.sysbus_i_io_ready = s_ready;
  assign bus.sysbus_i_io_data = s_data;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic in_window(input logic [31:0] a);
    return (a & MASK) == BASE && a[1:0] == 2'b00;
  endfunction
  // registered IO slave: raises ready s_delay cycles after valid, holds it until valid drops
  always @(posedge clk) begin
    if (s_stuck) s_ready <= 1'b1;
    else if (!bus.sysbus_o_io_valid) begin
      s_ready <= 1'b0;
      s_wcnt <= 0;
    end else if (!s_ready) begin
      s_wcnt <= s_wcnt + 1;
      if (!s_never && s_wcnt >= s_delay) begin
        s_ready <= 1'b1;
        s_data <= s_fix_en ? s_fix : $urandom;
      end
    end
  end
  bit started = 0;
  int cyc = 0;
  int m_acc = 0;
  logic m_open = 1'b0, m_drain = 1'b0, m_w = 1'b0, e_rv = 1'b0, e_err = 1'b0, rdy_now;
  logic [31:0] m_addr = '0, m_data = '0, e_rd = '0;
  // model: one open IO transaction at a time, resolved by slave ready or by elapsed cycles
  always @(posedge clk) begin
    rdy_now = !rst && !s_ready && !m_open && !m_drain;
    if (rst) begin
      m_open = 1'b0; m_drain = 1'b0; m_w = 1'b0; m_addr = '0; m_data = '0;
      e_rv = 1'b0; e_err = 1'b0; e_rd = '0;
    end else begin
      e_rv = 1'b0; e_err = 1'b0; e_rd = '0;
      if (m_drain && !s_ready) m_drain = 1'b0;
      if (m_open) begin
        if (s_ready) begin
          m_open = 1'b0; m_drain = 1'b1; e_rv = 1'b1; e_rd = m_w ? 32'h0 : s_data;
        end else if (cyc - m_acc == TO) begin
          m_open = 1'b0; m_drain = 1'b1; e_rv = 1'b1; e_err = 1'b1;
        end
      end else if (rdy_now && bus.cpu_req_valid) begin
        if (in_window(bus.cpu_req_addr)) begin
          m_open = 1'b1; m_acc = cyc; m_w = bus.cpu_req_write; m_addr = bus.cpu_req_addr;
          m_data = bus.cpu_req_write ? bus.cpu_req_data : 32'h0;
        end else begin
          e_rv = 1'b1; e_err = 1'b1;
        end
      end
    end
    cyc++;
    started = 1;
  end
  // compare every output against the model mid-cycle
  always @(negedge clk) if (started) begin
    chk("req_ready", 32'(bus.cpu_req_ready), 32'(!rst && !s_ready && !m_open && !m_drain));
    chk("io_valid", 32'(bus.sysbus_o_io_valid), 32'(m_open));
    chk("io_write", 32'(bus.sysbus_o_io_write), 32'(m_w));
    chk("io_addr", bus.sysbus_o_io_addr, m_addr);
    chk("io_data", bus.sysbus_o_io_data, m_data);
    chk("resp_valid", 32'(bus.cpu_resp_valid), 32'(e_rv));
    chk("resp_err", 32'(bus.cpu_resp_err), 32'(e_err));
    chk("resp_data", bus.cpu_resp_data, e_rd);
  end
  int io_cycles = 0, resp_cnt = 0;
  logic cap_w = 1'b0;
  logic [31:0] cap_addr = '0, cap_data = '0;
  always @(negedge clk) begin
    if (bus.sysbus_o_io_valid) begin
      io_cycles++;
      cap_w = bus.sysbus_o_io_write;
      cap_addr = bus.sysbus_o_io_addr;
      cap_data = bus.sysbus_o_io_data;
    end
    if (bus.cpu_resp_valid) resp_cnt++;
  end
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit ok = 0;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_write = w;
    bus.cpu_req_addr = a;
    bus.cpu_req_data = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.cpu_req_ready;
      @(posedge clk);
      #1;
    end
    bus.cpu_req_valid = 1'b0;
    if (!ok) chk("accept", 32'd0, 32'd1);
  endtask
  task automatic get_resp(output logic [31:0] d, output logic e, output int lat);
    lat = 0; d = '0; e = 1'b0;
    for (int i = 0; i < TO + 10; i++) begin
      @(negedge clk);
      if (bus.cpu_resp_valid) begin
        d = bus.cpu_resp_data; e = bus.cpu_resp_err; lat = i + 1;
        break;
      end
    end
    if (lat == 0) chk("resp_seen", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask
  logic [31:0] rd, ra;
  logic re;
  int lat, n0, n1;
  initial begin
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_write = 1'b0;
    bus.cpu_req_addr = '0;
    bus.cpu_req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_resp_valid", 32'(bus.cpu_resp_valid), 32'd0);
    chk("rst_io_valid", 32'(bus.sysbus_o_io_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = io_cycles;
    send(1'b1, 32'hfe000000, 32'h41);
    get_resp(rd, re, lat);
    chk("t1_err", 32'(re), 32'd0);
    chk("t1_data", rd, 32'h0);
    chk("t1_lat", 32'(lat), 32'd3);
    chk("t1_io_cycles", 32'(io_cycles - n0), 32'd2);
    chk("t1_addr", cap_addr, 32'hfe000000);
    chk("t1_write", 32'(cap_w), 32'd1);
    chk("t1_wdata", cap_data, 32'h41);
    s_fix_en = 1'b1;
    s_fix = 32'h1234;
    send(1'b0, 32'hfe000010, 32'hdeadbeef);
    get_resp(rd, re, lat);
    chk("t2_err", 32'(re), 32'd0);
    chk("t2_data", rd, 32'h00001234);
    chk("t2_io_data", cap_data, 32'h0);
    chk("t2_write", 32'(cap_w), 32'd0);
    @(negedge clk);
    chk("t2_drain_ready", 32'(bus.cpu_req_ready), 32'd0);
    @(negedge clk);
    chk("t2_idle_ready", 32'(bus.cpu_req_ready), 32'd1);
    @(posedge clk);
    #1;
    s_fix_en = 1'b0;
    n0 = io_cycles;
    send(1'b0, 32'h80000000, 32'h0);
    get_resp(rd, re, lat);
    chk("t3_err", 32'(re), 32'd1);
    chk("t3_data", rd, 32'h0);
    chk("t3_lat", 32'(lat), 32'd1);
    chk("t3_io_cycles", 32'(io_cycles - n0), 32'd0);
    send(1'b0, 32'hfe000012, 32'h0);
    get_resp(rd, re, lat);
    chk("t4_err", 32'(re), 32'd1);
    chk("t4_lat", 32'(lat), 32'd1);
    chk("t4_io_cycles", 32'(io_cycles - n0), 32'd0);
    s_never = 1'b1;
    n0 = io_cycles;
    send(1'b0, 32'hfe000020, 32'h0);
    get_resp(rd, re, lat);
    chk("t5_err", 32'(re), 32'd1);
    chk("t5_data", rd, 32'h0);
    chk("t5_lat", 32'(lat), 32'(TO + 1));
    chk("t5_io_cycles", 32'(io_cycles - n0), 32'(TO));
    s_never = 1'b0;
    send(1'b1, 32'hfe000004, 32'h5);
    get_resp(rd, re, lat);
    chk("t5_next_err", 32'(re), 32'd0);
    s_never = 1'b1;
    send(1'b0, 32'hfe000030, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    n1 = resp_cnt;
    s_stuck = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_ready_held", 32'(bus.cpu_req_ready), 32'd0);
      chk("t6_io_valid", 32'(bus.sysbus_o_io_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    s_stuck = 1'b0;
    s_never = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_ready_back", 32'(bus.cpu_req_ready), 32'd1);
    chk("t6_no_resp", 32'(resp_cnt - n1), 32'd0);
    @(posedge clk);
    #1;
    for (int t = 0; t < 250; t++) begin
      s_delay = $urandom_range(0, 9);
      s_never = $urandom_range(0, 9) == 0;
      case ($urandom_range(0, 3))
        0: ra = {8'hfe, 22'($urandom), 2'b00};
        1: ra = {8'hfe, 22'($urandom), 2'($urandom_range(1, 3))};
        2: ra = $urandom;
        default: ra = {8'hfe, 24'($urandom)};
      endcase
      send(1'($urandom), ra, $urandom);
      get_resp(rd, re, lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    s_never = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
